// File: rtl/midi_note_rx.sv
// MIDI serial receiver and monophonic Note On/Off parser for one channel.
// Drives the key number, velocity and gate to the phase-increment lookup stage.
module midi_note_rx #(
    parameter int CLK_HZ  = 50000000,
    parameter int BAUD    = 31250,
    parameter int CHANNEL = 0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX,
    output logic [7:0] NOTE,
    output logic [6:0] VELOCITY,
    output logic       GATE,
    output logic       NOTE_STB,
    output logic       FRAME_ERR
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);
    localparam logic [3:0]    CH      = 4'(CHANNEL);
    localparam logic [7:0]    NOTE_ON  = {4'h9, CH};
    localparam logic [7:0]    NOTE_OFF = {4'h8, CH};

    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;
    typedef enum logic [1:0] {P_WAIT_STATUS, P_WAIT_D1, P_WAIT_D2} parse_state_t;

    uart_state_t  u_state, u_next;
    parse_state_t p_state, p_next;

    logic          sync1, sync2, rx_prev, fall;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    bit_idx, bit_next;
    logic [7:0]    shreg, sh_next;
    logic          byte_ok, byte_bad;

    logic [7:0] rs, rs_next, d1, d1_next;
    logic       rs_valid, rsv_next;
    logic       msg_done;
    logic [7:0] msg_d1, msg_d2;
    logic [7:0] note_next;
    logic [6:0] vel_next;
    logic       gate_next, stb_next, ferr_next;

    // Sync flops reset low so a line already low after reset is not taken as a start edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            rx_prev <= 1'b0;
        end else begin
            sync1   <= RX;
            sync2   <= sync1;
            rx_prev <= sync2;
        end
    end

    assign fall = rx_prev & ~sync2;

    always_ff @(posedge CLK) begin
        if (RST) begin
            u_state <= U_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            u_state <= u_next;
            cnt     <= cnt_next;
            bit_idx <= bit_next;
            shreg   <= sh_next;
        end
    end

    always_comb begin
        u_next   = u_state;
        cnt_next = cnt + 1'b1;
        bit_next = bit_idx;
        sh_next  = shreg;
        byte_ok  = 1'b0;
        byte_bad = 1'b0;
        case (u_state)
            U_IDLE: begin
                cnt_next = '0;
                if (fall) u_next = U_START;
            end
            U_START: begin
                if (cnt == HALF_M1) begin
                    cnt_next = '0;
                    bit_next = '0;
                    u_next   = sync2 ? U_IDLE : U_DATA;
                end
            end
            U_DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_next = '0;
                    sh_next  = {sync2, shreg[7:1]};
                    bit_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) u_next = U_STOP;
                end
            end
            U_STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_next = '0;
                    u_next   = U_IDLE;
                    byte_ok  = sync2;
                    byte_bad = ~sync2;
                end
            end
            default: u_next = U_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            p_state   <= P_WAIT_STATUS;
            rs        <= '0;
            rs_valid  <= 1'b0;
            d1        <= '0;
            NOTE      <= '0;
            VELOCITY  <= '0;
            GATE      <= 1'b0;
            NOTE_STB  <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            p_state   <= p_next;
            rs        <= rs_next;
            rs_valid  <= rsv_next;
            d1        <= d1_next;
            NOTE      <= note_next;
            VELOCITY  <= vel_next;
            GATE      <= gate_next;
            NOTE_STB  <= stb_next;
            FRAME_ERR <= ferr_next;
        end
    end

    // The parser consumes the byte in the stop-sample cycle, so outputs land one cycle later.
    always_comb begin
        p_next    = p_state;
        rs_next   = rs;
        rsv_next  = rs_valid;
        d1_next   = d1;
        note_next = NOTE;
        vel_next  = VELOCITY;
        gate_next = GATE;
        stb_next  = 1'b0;
        ferr_next = 1'b0;
        msg_done  = 1'b0;
        msg_d1    = '0;
        msg_d2    = '0;

        if (byte_bad) begin
            ferr_next = 1'b1;
            rsv_next  = 1'b0;
            p_next    = P_WAIT_STATUS;
        end else if (byte_ok) begin
            if (shreg >= 8'hF8) begin
                p_next = p_state;
            end else if (shreg >= 8'hF0) begin
                rsv_next = 1'b0;
                p_next   = P_WAIT_STATUS;
            end else if (shreg[7]) begin
                rs_next  = shreg;
                rsv_next = 1'b1;
                p_next   = P_WAIT_D1;
            end else begin
                case (p_state)
                    P_WAIT_STATUS, P_WAIT_D1: begin
                        if (p_state == P_WAIT_D1 || rs_valid) begin
                            if (rs[7:4] == 4'hC || rs[7:4] == 4'hD) begin
                                msg_done = 1'b1;
                                msg_d1   = shreg;
                                p_next   = P_WAIT_STATUS;
                            end else begin
                                d1_next = shreg;
                                p_next  = P_WAIT_D2;
                            end
                        end
                    end
                    P_WAIT_D2: begin
                        msg_done = 1'b1;
                        msg_d1   = d1;
                        msg_d2   = shreg;
                        p_next   = P_WAIT_STATUS;
                    end
                    default: p_next = P_WAIT_STATUS;
                endcase
            end
        end

        if (msg_done) begin
            if (rs == NOTE_ON && msg_d2 != 8'h00) begin
                note_next = {1'b0, msg_d1[6:0]};
                vel_next  = msg_d2[6:0];
                gate_next = 1'b1;
                stb_next  = 1'b1;
            end else if ((rs == NOTE_OFF || (rs == NOTE_ON && msg_d2 == 8'h00))
                         && msg_d1[6:0] == NOTE[6:0] && GATE) begin
                gate_next = 1'b0;
                stb_next  = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_midi_note_rx.sv
// Directed bench for midi_note_rx: serial MIDI stimulus, immediate-assertion checks.
// A reduced clock rate keeps the bit period at 16 cycles.
module tb_midi_note_rx;

    localparam int CLK_HZ = 500000;
    localparam int BAUD   = 31250;
    localparam int DIV    = CLK_HZ / BAUD;
    // RX fall to strobe visible: 2 sync flops, half-bit start sample, 9 full bits, 1 register.
    localparam int LAT    = DIV / 2 + 9 * DIV + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] note;
    logic [6:0] velocity;
    logic       gate, note_stb, frame_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int stb_cnt = 0;
    int ferr_cnt = 0;
    int stb_cyc = 0;
    int start_cyc = 0;
    int viol = 0;
    int s_base = 0;
    int f_base = 0;
    logic [7:0] prev_note;
    logic [6:0] prev_vel;
    logic       prev_gate;

    midi_note_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .CHANNEL(0)) dut (
        .CLK(clk), .RST(rst), .RX(rx),
        .NOTE(note), .VELOCITY(velocity), .GATE(gate),
        .NOTE_STB(note_stb), .FRAME_ERR(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: counts strobes and flags any output change outside a strobe cycle.
    always @(negedge clk) begin
        if (note_stb) begin
            stb_cnt <= stb_cnt + 1;
            stb_cyc <= cyc;
        end
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
        if (!rst && !note_stb &&
            (note !== prev_note || velocity !== prev_vel || gate !== prev_gate))
            viol <= viol + 1;
        prev_note <= note;
        prev_vel  <= velocity;
        prev_gate <= gate;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        start_cyc = cyc;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx = stop_bit;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        send_byte(b, 1'b1);
    endtask

    task automatic mark();
        repeat (2) @(negedge clk);
        s_base = stb_cnt;
        f_base = ferr_cnt;
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        // Reset with RX idle high for three bit periods.
        @(negedge clk);
        rst = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        rst = 1'b0;
        repeat (DIV) @(negedge clk);
        check("rst_note", note, 8'h00);
        check("rst_vel", velocity, 7'h00);
        check("rst_gate", gate, 1'b0);
        check("rst_stb", stb_cnt, 0);
        check("rst_ferr", ferr_cnt, 0);

        // Note On 0x45 vel 0x64, strobe latency measured from the third byte.
        mark();
        send(8'h90); send(8'h45); send(8'h64);
        settle();
        check("on1_note", note, 8'h45);
        check("on1_vel", velocity, 7'h64);
        check("on1_gate", gate, 1'b1);
        check("on1_stb", stb_cnt - s_base, 1);
        check("on1_lat", stb_cyc - start_cyc, LAT);

        // Running status Note On.
        mark();
        send(8'h48); send(8'h50);
        settle();
        check("rs_on_note", note, 8'h48);
        check("rs_on_vel", velocity, 7'h50);
        check("rs_on_gate", gate, 1'b1);
        check("rs_on_stb", stb_cnt - s_base, 1);

        // Velocity-0 Note On for a key that is not sounding.
        mark();
        send(8'h45); send(8'h00);
        settle();
        check("off_miss_note", note, 8'h48);
        check("off_miss_gate", gate, 1'b1);
        check("off_miss_stb", stb_cnt - s_base, 0);

        // Matching Note Off releases the gate but holds key and velocity.
        mark();
        send(8'h80); send(8'h48); send(8'h10);
        settle();
        check("off_note", note, 8'h48);
        check("off_vel", velocity, 7'h50);
        check("off_gate", gate, 1'b0);
        check("off_stb", stb_cnt - s_base, 1);

        // Real-time byte between D1 and D2.
        mark();
        send(8'h90); send(8'h3C); send(8'hF8); send(8'h7F);
        settle();
        check("rt_note", note, 8'h3C);
        check("rt_vel", velocity, 7'h7F);
        check("rt_gate", gate, 1'b1);
        check("rt_stb", stb_cnt - s_base, 1);

        // Program change running status swallows the following data bytes.
        mark();
        send(8'hC0); send(8'h05); send(8'h3E); send(8'h20);
        settle();
        check("pc_note", note, 8'h3C);
        check("pc_vel", velocity, 7'h7F);
        check("pc_stb", stb_cnt - s_base, 0);

        // Note On for another channel.
        mark();
        send(8'h91); send(8'h40); send(8'h40);
        settle();
        check("ch1_note", note, 8'h3C);
        check("ch1_gate", gate, 1'b1);
        check("ch1_stb", stb_cnt - s_base, 0);

        // Framing error after 0x90 clears running status; 0x40 0x40 must not play.
        mark();
        send(8'h90);
        send_byte(8'h55, 1'b0);
        repeat (DIV) @(negedge clk);
        send(8'h40); send(8'h40);
        settle();
        check("ferr_cnt", ferr_cnt - f_base, 1);
        check("ferr_stb", stb_cnt - s_base, 0);
        check("ferr_note", note, 8'h3C);
        check("ferr_vel", velocity, 7'h7F);

        // Short low glitch on RX.
        mark();
        rx = 1'b0;
        repeat (DIV * 3 / 10) @(negedge clk);
        rx = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        check("glitch_stb", stb_cnt - s_base, 0);
        check("glitch_ferr", ferr_cnt - f_base, 0);
        check("glitch_note", note, 8'h3C);

        // Reset during data bit 4 of the key byte (RX low at that point).
        send(8'h90);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = ((8'h45 >> i) & 8'h01) != 0;
            repeat (DIV) @(negedge clk);
        end
        rx = 1'b0;
        repeat (DIV / 2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        check("mid_rst_note", note, 8'h00);
        check("mid_rst_vel", velocity, 7'h00);
        check("mid_rst_gate", gate, 1'b0);

        mark();
        send(8'h90); send(8'h30); send(8'h30);
        settle();
        check("post_rst_note", note, 8'h30);
        check("post_rst_vel", velocity, 7'h30);
        check("post_rst_gate", gate, 1'b1);
        check("post_rst_stb", stb_cnt - s_base, 1);
        check("post_rst_ferr", ferr_cnt - f_base, 0);

        check("static_outputs", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
